// File: rtl/switch_mcu_pkg.sv
// Shared types and AHB-Lite encodings for the switch MCU load/store path.
package switch_mcu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Enum value equals the bit position of the matching one-hot select.
    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    function automatic logic [2:0] op_hsize(input lsu_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return HSIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return HSIZE_HALF;
            default:              return HSIZE_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(input lsu_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/switch_mcu_lsu_align.sv
// Combinational store-lane replication and load lane extraction with sign/zero extension.
module switch_mcu_lsu_align
    import switch_mcu_pkg::*;
(
    input  lsu_op_e     i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_hrdata,
    output logic [31:0] o_hwdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_hrdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_hrdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        case (i_op)
            OP_SB:   o_hwdata = {4{i_wdata[7:0]}};
            OP_SH:   o_hwdata = {2{i_wdata[15:0]}};
            default: o_hwdata = i_wdata;
        endcase
    end

    always_comb begin
        case (i_op)
            OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_rdata = {24'd0, w_byte};
            OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_rdata = {16'd0, w_half};
            OP_LW:   o_rdata = i_hrdata;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/switch_mcu_lsu.sv
// RV32I load/store unit issuing one AHB-Lite single transfer per request.
// SWITCH_MCU_LSU_MISALIGN_TRAP_EN: trap misaligned half/word requests instead of aligning them.
module switch_mcu_lsu
    import switch_mcu_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [3:0] HPROT_DATA     = 4'b0011
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_req,
    input  logic        in_lb,
    input  logic        in_lh,
    input  logic        in_lw,
    input  logic        in_lbu,
    input  logic        in_lhu,
    input  logic        in_sb,
    input  logic        in_sh,
    input  logic        in_sw,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_err,
    output logic        out_misalign,
    output logic        out_rd_we,
    output logic [4:0]  out_rd,
    output logic [31:0] out_rd_wdata,
    output logic [31:0] out_haddr,
    output logic        out_hwrite,
    output logic [2:0]  out_hsize,
    output logic [2:0]  out_hburst,
    output logic [3:0]  out_hprot,
    output logic [1:0]  out_htrans,
    output logic        out_hmastlock,
    output logic [31:0] out_hwdata,
    input  logic        in_hready,
    input  logic        in_hresp,
    input  logic [31:0] in_hrdata
);

    localparam int WDOG_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    lsu_state_e        r_state, w_state_nxt;
    lsu_op_e           r_op, w_req_op;
    logic [31:0]       r_addr, r_wdata, r_hrdata;
    logic [4:0]        r_rd;
    logic              r_err, r_misalign;
    logic [WDOG_W-1:0] r_wdog, w_wdog_inc;

    logic [7:0]  w_sel;
    logic [3:0]  w_sel_cnt;
    logic        w_sel_ok, w_trap, w_timeout, w_bus, w_store, w_load;
    logic [2:0]  w_req_size;
    logic [31:0] w_req_addr, w_hwdata, w_rdata;

    assign w_sel = {in_sw, in_sh, in_sb, in_lhu, in_lbu, in_lw, in_lh, in_lb};

    always_comb begin
        w_req_op  = OP_LB;
        w_sel_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_sel[i]) begin
                w_req_op  = lsu_op_e'(3'(i));
                w_sel_cnt = w_sel_cnt + 4'd1;
            end
        end
    end

    assign w_sel_ok   = (w_sel_cnt == 4'd1);
    assign w_req_size = op_hsize(w_req_op);

`ifdef SWITCH_MCU_LSU_MISALIGN_TRAP_EN
    assign w_trap     = w_sel_ok &&
                        (((w_req_size == HSIZE_HALF) && in_addr[0]) ||
                         ((w_req_size == HSIZE_WORD) && (in_addr[1:0] != 2'b00)));
    assign w_req_addr = in_addr;
`else
    assign w_trap = 1'b0;
    always_comb begin
        case (w_req_size)
            HSIZE_HALF: w_req_addr = {in_addr[31:1], 1'b0};
            HSIZE_WORD: w_req_addr = {in_addr[31:2], 2'b00};
            default:    w_req_addr = in_addr;
        endcase
    end
`endif

    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_wdog_inc == WDOG_W'(TIMEOUT_CYCLES));

    // NOTE: default assignment first so no path through the case leaves w_state_nxt unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_req) w_state_nxt = (!w_sel_ok || w_trap) ? ST_RESP : ST_ADDR;
            ST_ADDR: if (in_hready) w_state_nxt = ST_DATA;
                     else if (w_timeout) w_state_nxt = ST_RESP;
            ST_DATA: if (in_hready || w_timeout) w_state_nxt = ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state    <= ST_IDLE;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            r_wdog     <= '0;
            r_rd       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_wdog <= '0;
                    if (in_req) begin
                        r_rd       <= in_rd;
                        r_err      <= !w_sel_ok || w_trap;
                        r_misalign <= w_trap;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    r_wdog <= in_hready ? '0 : w_wdog_inc;
                    if (((r_state == ST_DATA) && in_hready && in_hresp) || (!in_hready && w_timeout))
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; every output they reach is gated by the state.
    always_ff @(posedge in_clk) begin
        if ((r_state == ST_IDLE) && in_req) begin
            r_op    <= w_req_op;
            r_addr  <= w_req_addr;
            r_wdata <= in_wdata;
        end
        if ((r_state == ST_DATA) && in_hready)
            r_hrdata <= in_hrdata;
    end

    switch_mcu_lsu_align u_align (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_hrdata  (r_hrdata),
        .o_hwdata  (w_hwdata),
        .o_rdata   (w_rdata)
    );

    assign w_bus   = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_store = op_is_store(r_op);
    assign w_load  = !w_store;

    assign out_busy      = (r_state != ST_IDLE);
    assign out_done      = (r_state == ST_RESP);
    assign out_err       = out_done && r_err;
    assign out_misalign  = out_done && r_misalign;
    assign out_rd_we     = out_done && w_load && !r_err && (r_rd != 5'd0);
    assign out_rd        = out_done ? r_rd : 5'd0;
    assign out_rd_wdata  = out_rd_we ? w_rdata : 32'd0;

    assign out_haddr     = w_bus ? r_addr : 32'd0;
    assign out_hwrite    = w_bus && w_store;
    assign out_hsize     = w_bus ? op_hsize(r_op) : 3'b000;
    assign out_htrans    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign out_hwdata    = ((r_state == ST_DATA) && w_store) ? w_hwdata : 32'd0;
    assign out_hburst    = HBURST_SINGLE;
    assign out_hprot     = HPROT_DATA;
    assign out_hmastlock = 1'b0;

endmodule

// File: tb/tb_switch_mcu_lsu.sv
// Randomized scoreboard bench for switch_mcu_lsu: AHB slave driver, bus and writeback monitors.
module tb_switch_mcu_lsu;

    localparam int         TO    = 4;
    localparam logic [3:0] HPROT = 4'b0011;
`ifdef SWITCH_MCU_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [7:0] S_LB = 8'h01, S_LH = 8'h02, S_LW = 8'h04, S_LBU = 8'h08;
    localparam logic [7:0] S_LHU = 8'h10, S_SB = 8'h20, S_SH = 8'h40, S_SW = 8'h80;

    logic        in_clk = 1'b0, in_rst = 1'b1, in_req = 1'b0;
    logic        in_lb = 0, in_lh = 0, in_lw = 0, in_lbu = 0, in_lhu = 0, in_sb = 0, in_sh = 0, in_sw = 0;
    logic [31:0] in_addr = '0, in_wdata = '0, in_hrdata = '0;
    logic [4:0]  in_rd = '0;
    logic        in_hready = 1'b1, in_hresp = 1'b0;
    logic        out_busy, out_done, out_err, out_misalign, out_rd_we, out_hwrite, out_hmastlock;
    logic [4:0]  out_rd;
    logic [31:0] out_rd_wdata, out_haddr, out_hwdata;
    logic [2:0]  out_hsize, out_hburst;
    logic [3:0]  out_hprot;
    logic [1:0]  out_htrans;

    switch_mcu_lsu #(.TIMEOUT_CYCLES(TO), .HPROT_DATA(HPROT)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_req(in_req),
        .in_lb(in_lb), .in_lh(in_lh), .in_lw(in_lw), .in_lbu(in_lbu), .in_lhu(in_lhu),
        .in_sb(in_sb), .in_sh(in_sh), .in_sw(in_sw),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_busy(out_busy), .out_done(out_done), .out_err(out_err), .out_misalign(out_misalign),
        .out_rd_we(out_rd_we), .out_rd(out_rd), .out_rd_wdata(out_rd_wdata),
        .out_haddr(out_haddr), .out_hwrite(out_hwrite), .out_hsize(out_hsize),
        .out_hburst(out_hburst), .out_hprot(out_hprot), .out_htrans(out_htrans),
        .out_hmastlock(out_hmastlock), .out_hwdata(out_hwdata),
        .in_hready(in_hready), .in_hresp(in_hresp), .in_hrdata(in_hrdata)
    );

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic        mis;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] hwdata;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int total = 0, bad = 0;
    int unsigned cyc = 0;

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    function automatic logic [2:0] size_of(input int op);
        case (op)
            0, 3, 5: return 3'b000;
            1, 4, 6: return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input int op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> ((a % 4) * 8)) & 32'hFF;
        h = (d >> (((a / 2) % 2) * 16)) & 32'hFFFF;
        case (op)
            0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3:       return b;
            1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4:       return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_hwdata(input int op, input logic [31:0] w);
        case (op)
            5:       return (w & 32'hFF) * 32'h0101_0101;
            6:       return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    task automatic drive_sel(input logic [7:0] s);
        {in_sw, in_sh, in_sb, in_lhu, in_lbu, in_lw, in_lh, in_lb} = s;
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {out_busy, out_done, out_err, out_misalign, out_rd_we, out_rd, out_rd_wdata,
                     out_haddr, out_hwrite, out_hsize, out_htrans, out_hwdata, out_hmastlock,
                     out_hburst}, '0);
        check({name, "_hprot"}, out_hprot, HPROT);
    endtask

    // Writeback monitor.
    always @(negedge in_clk) begin
        resp_t e;
        if (!in_rst) begin
            if (out_rd_we) check("we_only_with_done", out_done, 1'b1);
            if (out_done) begin
                check("done_expected", resp_q.size() != 0, 1'b1);
                if (resp_q.size() != 0) begin
                    e = resp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("err", out_err, e.err);
                    check("misalign", out_misalign, e.mis);
                    check("rd_we", out_rd_we, e.we);
                    if (e.we) check("rd", out_rd, e.rd);
                    check("rd_wdata", out_rd_wdata, e.wdata);
                    check("busy_at_done", out_busy, 1'b1);
                end
            end
        end
    end

    // Bus monitor.
    bit   mon_pend = 0, mon_data = 0;
    bus_t mon_cur;
    always @(negedge in_clk) begin
        if (in_rst) begin
            mon_pend = 0;
            mon_data = 0;
        end else begin
            if (mon_data && out_done) begin
                mon_data = 0;
            end else if (mon_data) begin
                check("data_htrans", out_htrans, 2'b00);
                check("data_haddr_held", out_haddr, mon_cur.addr);
                if (mon_cur.write) check("hwdata", out_hwdata, mon_cur.hwdata);
                if (in_hready) mon_data = 0;
            end
            if (out_htrans == 2'b10) begin
                if (!mon_pend) begin
                    check("nonseq_expected", bus_q.size() != 0, 1'b1);
                    if (bus_q.size() != 0) mon_cur = bus_q.pop_front();
                    mon_pend = 1;
                end
                check("haddr", out_haddr, mon_cur.addr);
                check("hwrite", out_hwrite, mon_cur.write);
                check("hsize", out_hsize, mon_cur.size);
                if (in_hready) begin
                    mon_pend = 0;
                    mon_data = 1;
                end
            end else begin
                mon_pend = 0;
            end
        end
    end

    task automatic run_txn(input logic [7:0] sel, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic [31:0] hrdata, input int wa, input int wd,
                           input bit resp_err, input bit junk, input int to_mode);
        int op = 0;
        bit legal, mis, trap, store, err, we;
        logic [2:0] size;
        logic [31:0] eaddr;
        int unsigned c0, done_c;
        resp_t r;
        bus_t b;
        legal = ($countones(sel) == 1);
        for (int i = 0; i < 8; i++) if (sel[i]) op = i;
        size  = size_of(op);
        store = (op >= 5);
        mis   = ((size == 3'b001) && addr[0]) || ((size == 3'b010) && (addr % 4 != 0));
        trap  = legal && mis && TRAP_EN;
        eaddr = (size == 3'b010) ? (addr & ~32'd3) : (size == 3'b001) ? (addr & ~32'd1) : addr;

        drive_sel(sel);
        in_addr  = addr;
        in_wdata = wdata;
        in_rd    = rd;
        in_req   = 1'b1;
        c0       = cyc;

        if (!legal || trap) begin
            r = '{cyc: c0 + 1, err: 1'b1, mis: trap, we: 1'b0, rd: rd, wdata: 32'd0};
            resp_q.push_back(r);
            step();
            in_req = 1'b0;
            step();
            return;
        end

        b = '{addr: eaddr, write: store, size: size, hwdata: model_hwdata(op, wdata)};
        bus_q.push_back(b);
        if (to_mode == 1)      begin err = 1'b1; done_c = c0 + 1 + TO; end
        else if (to_mode == 2) begin err = 1'b1; done_c = c0 + 2 + wa + TO; end
        else                   begin err = resp_err; done_c = c0 + 3 + wa + wd; end
        we = !store && !err && (rd != 5'd0);
        r  = '{cyc: done_c, err: err, mis: 1'b0, we: we, rd: rd,
               wdata: we ? model_load(op, eaddr, hrdata) : 32'd0};
        resp_q.push_back(r);

        step();
        in_req = junk;
        if (junk) begin
            drive_sel($urandom);
            in_addr  = $urandom;
            in_wdata = $urandom;
            in_rd    = 5'($urandom);
        end
        if (to_mode == 1) begin
            in_hready = 1'b0;
            repeat (TO) step();
        end else begin
            repeat (wa) begin in_hready = 1'b0; step(); end
            in_hready = 1'b1;
            step();
            if (to_mode == 2) begin
                in_hready = 1'b0;
                repeat (TO) step();
            end else begin
                repeat (wd) begin
                    in_hready = 1'b0;
                    in_hresp  = 1'($urandom);
                    in_hrdata = $urandom;
                    step();
                end
                in_hready = 1'b1;
                in_hresp  = resp_err;
                in_hrdata = hrdata;
                step();
            end
        end
        in_req    = 1'b0;
        in_hready = 1'b1;
        in_hresp  = 1'b0;
        in_hrdata = $urandom;
        step();
    endtask

    task automatic reset_during_data();
        bus_t b;
        b = '{addr: 32'h2000_0100, write: 1'b0, size: 3'b010, hwdata: 32'd0};
        bus_q.push_back(b);
        drive_sel(S_LW);
        in_addr = 32'h2000_0100;
        in_rd   = 5'd9;
        in_req  = 1'b1;
        step();
        in_req    = 1'b0;
        in_hready = 1'b1;
        step();
        in_rst    = 1'b1;
        in_hready = 1'b0;
        step();
        check_idle_outputs("rst_in_data");
        in_rst    = 1'b0;
        in_hready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        logic [7:0] s;
        int tm;
        repeat (3) step();
        check_idle_outputs("reset");
        in_rst = 1'b0;
        step();
        check_idle_outputs("idle_after_reset");

        run_txn(S_LW,  32'h2000_0010, 32'h0,         5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        run_txn(S_LB,  32'h2000_0013, 32'h0,         5'd1, 32'h80FF_0000, 0, 0, 0, 0, 0);
        run_txn(S_LBU, 32'h2000_0013, 32'h0,         5'd2, 32'h80FF_0000, 0, 0, 0, 0, 0);
        run_txn(S_LH,  32'h2000_0012, 32'h0,         5'd3, 32'h80FF_0000, 0, 0, 0, 0, 0);
        run_txn(S_LHU, 32'h2000_0012, 32'h0,         5'd4, 32'h80FF_0000, 1, 1, 0, 0, 0);
        run_txn(S_SB,  32'h2000_0001, 32'h1234_56AB, 5'd6, 32'h0,         0, 0, 0, 0, 0);
        run_txn(S_SH,  32'h2000_0006, 32'h1234_56AB, 5'd6, 32'h0,         1, 0, 0, 0, 0);
        run_txn(S_SW,  32'h2000_0040, 32'hCAFE_F00D, 5'd0, 32'h0,         2, 3, 1, 0, 0);
        run_txn(S_LW,  32'h2000_0020, 32'h0,         5'd7, 32'h5555_AAAA, 0, 0, 0, 0, 1);
        run_txn(S_SH,  32'h2000_0024, 32'hBEEF_1234, 5'd7, 32'h0,         1, 0, 0, 0, 2);
        run_txn(S_LW,  32'h2000_0002, 32'h0,         5'd8, 32'h1122_3344, 0, 0, 0, 0, 0);
        run_txn(S_LH,  32'h2000_0003, 32'h0,         5'd8, 32'h1122_3344, 0, 0, 0, 0, 0);
        run_txn(8'h00, 32'h2000_0000, 32'h0,         5'd9, 32'h0,         0, 0, 0, 0, 0);
        run_txn(8'h03, 32'h2000_0000, 32'h0,         5'd9, 32'h0,         0, 0, 0, 0, 0);
        run_txn(S_LW,  32'h2000_0030, 32'h0,         5'd0, 32'h7777_7777, 0, 0, 0, 0, 0);
        run_txn(S_LB,  32'h2000_0031, 32'h0,         5'd10, 32'h0000_8000, 1, 2, 0, 1, 0);
        reset_during_data();

        for (int n = 0; n < 200; n++) begin
            s  = ($urandom_range(9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(7));
            tm = ($urandom_range(15) == 0) ? $urandom_range(2, 1) : 0;
            run_txn(s, $urandom, $urandom, 5'($urandom), $urandom,
                    $urandom_range(3), $urandom_range(3), ($urandom_range(7) == 0),
                    ($urandom_range(3) == 0), tm);
        end

        repeat (5) step();
        check("resp_q_drained", resp_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
